// File: rtl/id_dispatch_queue.sv
// In-order decode/dispatch queue between register read and the reservation stations.
// Allocates one ROB tag per queued instruction and captures pending operands from the writeback buses.
module id_dispatch_queue #(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 4,
    parameter int TAG_INVALID = 0,
    parameter int DEPTH       = 4,
    parameter int WB_PORTS    = 2,
    parameter int EX_UNITS    = 4,
    parameter int EXU_W       = 2,
    parameter int OP_W        = 6,
    parameter int ERR_UNIT    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXU_W-1:0]          in_ex_unit,
    input  logic [OP_W-1:0]           in_op,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [XLEN-1:0]           in_offset,
    input  logic [2:0]                in_width,
    input  logic                      in_jump,
    input  logic [2*TAG_W-1:0]        in_src_tag,
    input  logic [2*XLEN-1:0]         in_src_val,

    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
    input  logic [WB_PORTS*XLEN-1:0]  wb_data,

    input  logic                      rob_full,
    input  logic [TAG_W-1:0]          rob_tag,
    output logic                      rob_alloc,

    input  logic [EX_UNITS-1:0]       rs_full,

    input  logic                      jump_reset,
    output logic                      jump_stall,

    output logic                      out_valid,
    output logic [EXU_W-1:0]          out_ex_unit,
    output logic [OP_W-1:0]           out_op,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_offset,
    output logic [2:0]                out_width,
    output logic [2*TAG_W-1:0]        out_tag,
    output logic [2*XLEN-1:0]         out_val,
    output logic [TAG_W-1:0]          out_target
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int CODES = 1 << EXU_W;
    localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_INVALID);
    localparam logic [EXU_W-1:0] UNIT_ERR = EXU_W'(ERR_UNIT);

    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               jump_stall_q, jump_stall_d;

    logic [DEPTH-1:0]   ent_valid_q;
    logic [EXU_W-1:0]   ent_ex_unit_q [DEPTH];
    logic [OP_W-1:0]    ent_op_q      [DEPTH];
    logic [XLEN-1:0]    ent_pc_q      [DEPTH];
    logic [XLEN-1:0]    ent_offset_q  [DEPTH];
    logic [2:0]         ent_width_q   [DEPTH];
    logic [TAG_W-1:0]   ent_target_q  [DEPTH];
    logic [2*TAG_W-1:0] ent_tag_q     [DEPTH];
    logic [2*XLEN-1:0]  ent_val_q     [DEPTH];

    logic [2*TAG_W-1:0] snp_tag [DEPTH];
    logic [2*XLEN-1:0]  snp_val [DEPTH];
    logic [2*TAG_W-1:0] enq_tag;
    logic [2*XLEN-1:0]  enq_val;

    logic               head_present;
    logic [EXU_W-1:0]   head_ex_unit;
    logic               accept;
    logic               enq_write;
    logic [CODES-1:0]   rs_full_ext;

    // Returns {tag, value} after capturing a matching writeback; the lowest matching port wins.
    function automatic logic [TAG_W+XLEN-1:0] resolve(
        input logic [TAG_W-1:0]          tag,
        input logic [XLEN-1:0]           val,
        input logic [WB_PORTS-1:0]       v,
        input logic [WB_PORTS*TAG_W-1:0] t,
        input logic [WB_PORTS*XLEN-1:0]  d
    );
        logic [TAG_W+XLEN-1:0] r;
        r = {tag, val};
        if (tag != TAG_NONE) begin
            for (int p = WB_PORTS - 1; p >= 0; p--) begin
                if (v[p] && (t[p*TAG_W +: TAG_W] == tag)) begin
                    r = {TAG_NONE, d[p*XLEN +: XLEN]};
                end
            end
        end
        return r;
    endfunction

    // Unit codes with no reservation station are never reported full.
    for (genvar gi = 0; gi < CODES; gi++) begin : g_rs_full
        if (gi < EX_UNITS) begin : g_unit
            assign rs_full_ext[gi] = rs_full[gi];
        end else begin : g_none
            assign rs_full_ext[gi] = 1'b0;
        end
    end

    always_comb begin
        logic [TAG_W+XLEN-1:0] res;
        res     = '0;
        enq_tag = in_src_tag;
        enq_val = in_src_val;
        for (int e = 0; e < DEPTH; e++) begin
            snp_tag[e] = ent_tag_q[e];
            snp_val[e] = ent_val_q[e];
        end
        for (int s = 0; s < 2; s++) begin
            res = resolve(in_src_tag[s*TAG_W +: TAG_W], in_src_val[s*XLEN +: XLEN],
                          wb_valid, wb_tag, wb_data);
            enq_tag[s*TAG_W +: TAG_W] = res[XLEN +: TAG_W];
            enq_val[s*XLEN +: XLEN]   = res[XLEN-1:0];
            for (int e = 0; e < DEPTH; e++) begin
                res = resolve(ent_tag_q[e][s*TAG_W +: TAG_W], ent_val_q[e][s*XLEN +: XLEN],
                              wb_valid, wb_tag, wb_data);
                snp_tag[e][s*TAG_W +: TAG_W] = res[XLEN +: TAG_W];
                snp_val[e][s*XLEN +: XLEN]   = res[XLEN-1:0];
            end
        end
    end

    always_comb begin
        head_ex_unit = ent_ex_unit_q[rd_ptr_q];
        head_present = !rst && (count_q != '0);
        in_ready     = !rst && !flush && (count_q < CNT_W'(DEPTH)) && !rob_full && !jump_stall_q;
        accept       = in_valid && in_ready;
        enq_write    = accept && (in_ex_unit != UNIT_ERR);
        rob_alloc    = enq_write;
        out_valid    = head_present && !flush && !rs_full_ext[head_ex_unit];

        count_d  = count_q + CNT_W'(enq_write) - CNT_W'(out_valid);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_write);
        rd_ptr_d = rd_ptr_q + PTR_W'(out_valid);

        jump_stall_d = jump_stall_q;
        if (jump_reset) begin
            jump_stall_d = 1'b0;
        end else if (accept && in_jump) begin
            jump_stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            jump_stall_q <= 1'b0;
            ent_valid_q  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ent_ex_unit_q[e] <= '0;
                ent_op_q[e]      <= '0;
                ent_pc_q[e]      <= '0;
                ent_offset_q[e]  <= '0;
                ent_width_q[e]   <= '0;
                ent_target_q[e]  <= TAG_NONE;
                ent_tag_q[e]     <= {2{TAG_NONE}};
                ent_val_q[e]     <= '0;
            end
        end else begin
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            jump_stall_q <= jump_stall_d;
            // Write slot and head slot never coincide: that needs an empty or a full queue.
            for (int e = 0; e < DEPTH; e++) begin
                if (enq_write && (wr_ptr_q == PTR_W'(e))) begin
                    ent_valid_q[e]   <= 1'b1;
                    ent_ex_unit_q[e] <= in_ex_unit;
                    ent_op_q[e]      <= in_op;
                    ent_pc_q[e]      <= in_pc;
                    ent_offset_q[e]  <= in_offset;
                    ent_width_q[e]   <= in_width;
                    ent_target_q[e]  <= rob_tag;
                    ent_tag_q[e]     <= enq_tag;
                    ent_val_q[e]     <= enq_val;
                end else if (ent_valid_q[e]) begin
                    ent_tag_q[e] <= snp_tag[e];
                    ent_val_q[e] <= snp_val[e];
                    if (out_valid && (rd_ptr_q == PTR_W'(e))) begin
                        ent_valid_q[e] <= 1'b0;
                    end
                end
            end
        end
    end

    assign jump_stall  = jump_stall_q;
    assign out_ex_unit = head_present ? head_ex_unit            : '0;
    assign out_op      = head_present ? ent_op_q[rd_ptr_q]      : '0;
    assign out_pc      = head_present ? ent_pc_q[rd_ptr_q]      : '0;
    assign out_offset  = head_present ? ent_offset_q[rd_ptr_q]  : '0;
    assign out_width   = head_present ? ent_width_q[rd_ptr_q]   : '0;
    assign out_tag     = head_present ? snp_tag[rd_ptr_q]       : {2{TAG_NONE}};
    assign out_val     = head_present ? snp_val[rd_ptr_q]       : '0;
    assign out_target  = head_present ? ent_target_q[rd_ptr_q]  : TAG_NONE;

endmodule

// File: tb/tb_id_dispatch_queue.sv
// Bench for id_dispatch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_id_dispatch_queue;
    localparam int XLEN = 32, TAG_W = 4, DEPTH = 4, WB_PORTS = 2;
    localparam int EX_UNITS = 4, EXU_W = 2, OP_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst, flush, in_valid, in_ready, in_jump;
    logic [EXU_W-1:0]          in_ex_unit;
    logic [OP_W-1:0]           in_op;
    logic [XLEN-1:0]           in_pc, in_offset;
    logic [2:0]                in_width;
    logic [2*TAG_W-1:0]        in_src_tag;
    logic [2*XLEN-1:0]         in_src_val;
    logic [WB_PORTS-1:0]       wb_valid;
    logic [WB_PORTS*TAG_W-1:0] wb_tag;
    logic [WB_PORTS*XLEN-1:0]  wb_data;
    logic                      rob_full, rob_alloc;
    logic [TAG_W-1:0]          rob_tag;
    logic [EX_UNITS-1:0]       rs_full;
    logic                      jump_reset, jump_stall, out_valid;
    logic [EXU_W-1:0]          out_ex_unit;
    logic [OP_W-1:0]           out_op;
    logic [XLEN-1:0]           out_pc, out_offset;
    logic [2:0]                out_width;
    logic [2*TAG_W-1:0]        out_tag;
    logic [2*XLEN-1:0]         out_val;
    logic [TAG_W-1:0]          out_target;

    id_dispatch_queue #(
        .XLEN(XLEN), .TAG_W(TAG_W), .TAG_INVALID(0), .DEPTH(DEPTH), .WB_PORTS(WB_PORTS),
        .EX_UNITS(EX_UNITS), .EXU_W(EXU_W), .OP_W(OP_W), .ERR_UNIT(0)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ex_unit(in_ex_unit), .in_op(in_op),
        .in_pc(in_pc), .in_offset(in_offset), .in_width(in_width), .in_jump(in_jump),
        .in_src_tag(in_src_tag), .in_src_val(in_src_val),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .rob_full(rob_full), .rob_tag(rob_tag), .rob_alloc(rob_alloc),
        .rs_full(rs_full), .jump_reset(jump_reset), .jump_stall(jump_stall),
        .out_valid(out_valid), .out_ex_unit(out_ex_unit), .out_op(out_op), .out_pc(out_pc),
        .out_offset(out_offset), .out_width(out_width), .out_tag(out_tag), .out_val(out_val),
        .out_target(out_target)
    );

    typedef struct packed {
        logic [EXU_W-1:0]   ex;
        logic [OP_W-1:0]    op;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    off;
        logic [2:0]         w;
        logic [2*TAG_W-1:0] tags;
        logic [2*XLEN-1:0]  vals;
        logic [TAG_W-1:0]   target;
    } ent_t;

    ent_t model_q[$];
    logic model_jstall = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pending source picks up the first valid writeback port carrying its tag.
    function automatic ent_t snoop(input ent_t e);
        ent_t r;
        logic [TAG_W-1:0] t;
        r = e;
        for (int s = 0; s < 2; s++) begin
            t = e.tags[s*TAG_W +: TAG_W];
            if (t != 0) begin
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] == t) begin
                        r.tags[s*TAG_W +: TAG_W] = '0;
                        r.vals[s*XLEN +: XLEN]   = wb_data[p*XLEN +: XLEN];
                        break;
                    end
                end
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin : cmp
        logic exp_ready, exp_accept, exp_alloc, exp_ov;
        ent_t h, n;
        exp_ready  = !rst && !flush && (model_q.size() < DEPTH) && !rob_full && !model_jstall;
        exp_accept = in_valid && exp_ready;
        exp_alloc  = exp_accept && (in_ex_unit != 0);
        exp_ov     = 1'b0;
        h          = '0;
        if (model_q.size() > 0) begin
            h      = snoop(model_q[0]);
            exp_ov = !rst && !flush && !rs_full[h.ex];
        end
        check("in_ready", in_ready, exp_ready);
        check("rob_alloc", rob_alloc, exp_alloc);
        check("out_valid", out_valid, exp_ov);
        check("jump_stall", jump_stall, model_jstall);
        if (rst) check("rst_out_target", out_target, 0);
        if (exp_ov) begin
            check("out_ex_unit", out_ex_unit, h.ex);
            check("out_op", out_op, h.op);
            check("out_pc", out_pc, h.pc);
            check("out_offset", out_offset, h.off);
            check("out_width", out_width, h.w);
            check("out_tag", out_tag, h.tags);
            check("out_val", out_val, h.vals);
            check("out_target", out_target, h.target);
        end
        if (rst || flush) begin
            model_q.delete();
            model_jstall = 1'b0;
        end else begin
            if (exp_ov) void'(model_q.pop_front());
            foreach (model_q[i]) model_q[i] = snoop(model_q[i]);
            if (exp_alloc) begin
                n.ex = in_ex_unit; n.op = in_op; n.pc = in_pc; n.off = in_offset; n.w = in_width;
                n.tags = in_src_tag; n.vals = in_src_val; n.target = rob_tag;
                model_q.push_back(snoop(n));
            end
            if (jump_reset) model_jstall = 1'b0;
            else if (exp_accept && in_jump) model_jstall = 1'b1;
        end
    end

    task automatic idle();
        flush = 0; in_valid = 0; in_ex_unit = 0; in_op = 0; in_pc = 0; in_offset = 0;
        in_width = 0; in_jump = 0; in_src_tag = 0; in_src_val = 0; wb_valid = 0; wb_tag = 0;
        wb_data = 0; rob_full = 0; rob_tag = 0; rs_full = 0; jump_reset = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [EXU_W-1:0] ex, input logic [TAG_W-1:0] tg, input logic [XLEN-1:0] pc);
        in_valid = 1; in_ex_unit = ex; rob_tag = tg; in_pc = pc; in_op = 6'h11;
        in_src_tag = 0; in_src_val = {32'h0, pc};
    endtask

    int alloc_cnt;

    initial begin
        idle();
        rst = 1;
        repeat (3) cyc();
        rst = 0;
        #2;
        check("lit_reset_in_ready", in_ready, 1);
        check("lit_reset_out_valid", out_valid, 0);
        check("lit_reset_jump_stall", jump_stall, 0);
        check("lit_reset_out_target", out_target, 0);
        cyc();

        // Enqueue with src2 waiting on tag 3; writeback arrives in the dispatch cycle.
        in_valid = 1; in_ex_unit = 1; in_op = 6'h0A; in_pc = 32'h100; in_offset = 32'h20;
        in_width = 3'd2; in_src_tag = {4'd3, 4'd0}; in_src_val = {32'h0, 32'h1234}; rob_tag = 5;
        #2;
        check("lit_enq_alloc", rob_alloc, 1);
        check("lit_no_fallthrough", out_valid, 0);
        cyc();
        idle();
        wb_valid = 2'b10; wb_tag = {4'd3, 4'd0}; wb_data = {32'hDEAD, 32'h0};
        #2;
        check("lit_byp_valid", out_valid, 1);
        check("lit_byp_tag", out_tag, 0);
        check("lit_byp_val", out_val, {32'hDEAD, 32'h1234});
        check("lit_byp_target", out_target, 5);
        cyc();
        idle();

        // Fill the queue behind a full reservation station, then drain in order.
        rs_full = 4'b0010;
        alloc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            push(2'd1, 4'(8 + i), 32'h200 + 32'(4 * i));
            #2;
            if (rob_alloc) alloc_cnt++;
            if (i == 4) check("lit_full_in_ready", in_ready, 0);
            cyc();
        end
        check("lit_alloc_pulses", alloc_cnt, 4);
        in_valid = 0; rs_full = 0;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("lit_drain_valid", out_valid, 1);
            check("lit_drain_target", out_target, 8 + i);
            cyc();
        end
        #2;
        check("lit_drained", out_valid, 0);
        cyc();

        // Jump stall set, then released by jump_reset.
        push(2'd2, 4'd1, 32'h300); in_jump = 1;
        cyc();
        idle();
        #2;
        check("lit_jstall_set", jump_stall, 1);
        check("lit_jstall_ready", in_ready, 0);
        cyc();
        push(2'd3, 4'd2, 32'h304); in_jump = 1; jump_reset = 1;
        cyc();
        idle();
        #2;
        check("lit_jstall_clr", jump_stall, 0);
        push(2'd2, 4'd2, 32'h308); in_jump = 1; jump_reset = 1;
        cyc();
        idle();
        #2;
        check("lit_jreset_wins", jump_stall, 0);
        cyc();

        // ROB full blocks; ERR_UNIT is consumed without an entry.
        push(2'd1, 4'd3, 32'h400); rob_full = 1;
        #2;
        check("lit_robfull_ready", in_ready, 0);
        check("lit_robfull_alloc", rob_alloc, 0);
        cyc();
        idle();
        push(2'd0, 4'd4, 32'h404);
        #2;
        check("lit_err_ready", in_ready, 1);
        check("lit_err_alloc", rob_alloc, 0);
        cyc();
        idle();
        #2;
        check("lit_err_no_entry", out_valid, 0);
        cyc();

        // Flush three queued entries.
        rs_full = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            push(2'(i + 1), 4'(12 + i), 32'h500 + 32'(4 * i));
            cyc();
        end
        push(2'd1, 4'd15, 32'h50C); flush = 1; rs_full = 0;
        #2;
        check("lit_flush_out_valid", out_valid, 0);
        check("lit_flush_alloc", rob_alloc, 0);
        cyc();
        idle();
        #2;
        check("lit_flush_empty", out_valid, 0);
        cyc();

        // Reset while dispatching with a pending jump stall.
        rs_full = 4'b1111;
        push(2'd1, 4'd6, 32'h600);
        cyc();
        push(2'd1, 4'd7, 32'h604); in_jump = 1;
        cyc();
        idle();
        #2;
        check("lit_pre_rst_valid", out_valid, 1);
        rst = 1;
        #1;
        check("lit_rst_comb_valid", out_valid, 0);
        cyc();
        #2;
        check("lit_rst_jstall", jump_stall, 0);
        check("lit_rst_target", out_target, 0);
        rst = 0;
        #1;
        check("lit_rst_ready", in_ready, 1);
        check("lit_rst_empty", out_valid, 0);
        cyc();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 199) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            in_ex_unit = 2'($urandom_range(0, 3));
            in_op      = 6'($urandom);
            in_pc      = $urandom;
            in_offset  = $urandom;
            in_width   = 3'($urandom);
            in_jump    = ($urandom_range(0, 9) == 0);
            in_src_tag = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            in_src_val = {$urandom, $urandom};
            wb_valid   = 2'($urandom);
            wb_tag     = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            wb_data    = {$urandom, $urandom};
            rob_full   = ($urandom_range(0, 9) == 0);
            rob_tag    = 4'($urandom);
            for (int u = 0; u < EX_UNITS; u++) rs_full[u] = ($urandom_range(0, 9) < 3);
            jump_reset = ($urandom_range(0, 4) == 0);
            cyc();
        end
        idle();
        rst = 0;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_dispatch_queue.md
Name: id_dispatch_queue

Overview:
- Parametrised decode/dispatch stage that sits between the decoder/register-file read and the reservation stations (idex).
- Holds up to DEPTH decoded instructions in a FIFO and allocates one ROB tag per accepted instruction.
- Waiting operands are captured from WB_PORTS writeback buses at enqueue, every cycle while queued, and at dispatch.
- Each head instruction is dispatched to its execution unit when that unit's reservation station is not full.

Parameters:
XLEN, 32, operand/pc width
TAG_W, 4, ROB tag width
TAG_INVALID, 0, tag value meaning "operand ready"
DEPTH, 4, queue entries (power of two, >=2)
WB_PORTS, 2, number of writeback broadcast ports
EX_UNITS, 4, number of execution units / reservation stations
EXU_W, 2, ex_unit code width
OP_W, 6, op code width
ERR_UNIT, 0, ex_unit code of an invalid/nop instruction

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all queued instructions (mispredict)
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle when in_valid&&in_ready
in_ex_unit  in  EXU_W  target unit
in_op  in  OP_W  operation
in_pc  in  XLEN  instruction pc
in_offset  in  XLEN  branch offset
in_width  in  3  memory access width
in_jump  in  1  instruction is a control transfer needing fetch stall
in_src_tag  in  2*TAG_W  src1/src2 tags from register file
in_src_val  in  2*XLEN  src1/src2 values
wb_valid  in  WB_PORTS  writeback port valid
wb_tag  in  WB_PORTS*TAG_W  writeback tags
wb_data  in  WB_PORTS*XLEN  writeback data
rob_full  in  1  ROB cannot allocate
rob_tag  in  TAG_W  next free ROB tag
rob_alloc  out  1  ROB tag consumed this cycle
rs_full  in  EX_UNITS  per-unit reservation station full
jump_reset  in  1  branch resolved; release fetch
jump_stall  out  1  fetch stall
out_valid  out  1  head dispatched this cycle
out_ex_unit, out_op, out_pc, out_offset, out_width  out  as inputs  head fields
out_tag  out  2*TAG_W  head operand tags after bypass
out_val  out  2*XLEN  head operand values after bypass
out_target  out  TAG_W  head ROB tag

Behaviour:
- Reset (sync, rst=1 at posedge): count=0, rd/wr pointers=0, jump_stall=0, all entries invalid. out_valid=0, rob_alloc=0, in_ready=0 while rst is high; out_* data 0, out_target=TAG_INVALID.
- in_ready = !rst && !flush && count<DEPTH && !rob_full && !jump_stall.
- Accept (in_valid&&in_ready):
  - ex_unit!=ERR_UNIT: write the entry at wr_ptr with target=rob_tag; rob_alloc=1 combinationally this cycle; wr_ptr+1 mod DEPTH.
  - ex_unit==ERR_UNIT: consumed and dropped; no entry written, rob_alloc=0.
- Enqueue bypass: for each src whose tag!=TAG_INVALID and equals wb_tag[p] with wb_valid[p], store wb_data[p] and tag=TAG_INVALID. Lowest p wins on a multi-match.
- Snoop: each cycle, every valid queued entry applies the same match rule to its pending srcs.
- Dispatch: out_valid = count>0 && !rs_full[head.ex_unit] && !flush. out_* are combinational from the head entry with the same-cycle wb bypass applied to out_tag/out_val. On out_valid: rd_ptr+1, entry freed. No fall-through: an instruction accepted in cycle N is dispatched at cycle N+1 at the earliest.
- Simultaneous accept and dispatch: allowed, count unchanged. Because in_ready requires count<DEPTH, a full queue accepts nothing even if it dispatches that cycle.
- jump_stall: set at posedge after an accepted instruction with in_jump=1 (including an ERR_UNIT instruction). Cleared when jump_reset=1; jump_reset wins if both occur in the same cycle.
- flush: count, pointers and entries cleared next edge; jump_stall cleared; same-cycle accept and dispatch suppressed; rst has priority over flush.
- ROB tags wrap naturally; the queue never compares targets.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, jump_stall=0, out_target=0.
- Enqueue add with src_tag={3,0}, rob_tag=5; next cycle wb_valid[1]=1, wb_tag[1]=3, wb_data=0xDEAD -> dispatch cycle shows out_tag={0,0}, out_val[1]=0xDEAD, out_target=5.
- Fill 4 entries with rs_full[1]=1, all ex_unit=1 -> in_ready=0 after the 4th, rob_alloc pulses exactly 4. Deassert rs_full -> 4 dispatches in consecutive cycles, in FIFO order.
- in_jump=1 accepted -> jump_stall=1 and in_ready=0 from the next cycle. jump_reset and a new in_jump in the same cycle -> jump_stall=0.
- rob_full=1 with in_valid=1 -> in_ready=0, rob_alloc=0, queue unchanged. ERR_UNIT instruction -> accepted, no entry, rob_alloc=0.
- 3 entries queued, assert flush -> out_valid=0 that cycle, count=0 next cycle. rst asserted mid-dispatch -> all outputs at reset values on the next edge.
